// File: rtl/compress_pkg.sv
// Shared types and constants for the compressor code path.
// Code classes, their bit lengths and the packer FSM states.
package compress_pkg;

   localparam int TOTAL_BITS = 34;

   typedef enum logic [2:0] {
      ZZZZ = 3'b000,
      MMMM = 3'b001,
      ZZZX = 3'b010,
      MMMX = 3'b011,
      MMXX = 3'b100,
      XXXX = 3'b101
   } code_e;

   localparam logic [5:0] LEN_ZZZZ = 6'd2;
   localparam logic [5:0] LEN_MMMM = 6'd6;
   localparam logic [5:0] LEN_ZZZX = 6'd12;
   localparam logic [5:0] LEN_MMMX = 6'd16;
   localparam logic [5:0] LEN_MMXX = 6'd24;
   localparam logic [5:0] LEN_XXXX = 6'd34;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/code_length_decoder.sv
// Maps a code class to its bit length.
// Classes 110 and 111 are flagged illegal with zero length.
module code_length_decoder
   import compress_pkg::*;
(
   input  logic [2:0] code,
   output logic [5:0] len,
   output logic       illegal
);

   always_comb begin
      len     = '0;
      illegal = 1'b0;
      unique case (1'b1)
         (code == ZZZZ): len = LEN_ZZZZ;
         (code == MMMM): len = LEN_MMMM;
         (code == ZZZX): len = LEN_ZZZX;
         (code == MMMX): len = LEN_MMMX;
         (code == MMXX): len = LEN_MMXX;
         (code == XXXX): len = LEN_XXXX;
         default:        illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/code_bit_packer.sv
// Packs variable-length codes MSB-first into OUT_WIDTH words.
// A flush pads the residue with zeros and marks it as the last word.
module code_bit_packer
   import compress_pkg::*;
#(
   parameter int TOTAL_BITS = compress_pkg::TOTAL_BITS,
   parameter int OUT_WIDTH  = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2:0]            i_code,
   input  logic [TOTAL_BITS-1:0] i_compressed_word,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [OUT_WIDTH-1:0]  o_data,
   output logic                  o_last,
   output logic [6:0]            o_last_bits,
   output logic                  o_flush_done,
   output logic [CNT_WIDTH-1:0]  o_total_bits,
   output logic                  o_err
);

   localparam int BUF_W = OUT_WIDTH + TOTAL_BITS;
   localparam int FW    = $clog2(BUF_W + 1);

   if (OUT_WIDTH < TOTAL_BITS) begin : g_width_check
      $error("OUT_WIDTH must be >= TOTAL_BITS");
   end

   logic [BUF_W-1:0]      sbuf;
   logic [FW-1:0]         fill;
   state_e                state;

   logic [5:0]            len;
   logic                  illegal;
   logic                  out_free;
   logic                  take;
   logic                  take_code;
   logic [TOTAL_BITS-1:0] word;
   logic [BUF_W-1:0]      ins;
   logic [BUF_W-1:0]      nbuf;
   logic [FW-1:0]         nf;

   code_length_decoder u_dec (
      .code    (i_code),
      .len     (len),
      .illegal (illegal)
   );

   assign out_free  = !o_valid || i_ready;
   assign o_ready   = (state == S_RUN) && out_free;
   assign take      = i_valid && o_ready;
   assign take_code = take && !illegal;

   // Left-aligned insert: the code lands right after the current fill.
   always_comb begin
      word = i_compressed_word & ~({TOTAL_BITS{1'b1}} << len);
      ins  = BUF_W'(word);
      ins  = ins << (FW'(BUF_W) - fill - FW'(len));
      nbuf = sbuf | ins;
      nf   = fill + FW'(len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sbuf         <= '0;
         fill         <= '0;
         state        <= S_RUN;
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_last       <= 1'b0;
         o_last_bits  <= '0;
         o_flush_done <= 1'b0;
         o_total_bits <= '0;
         o_err        <= 1'b0;
      end else begin
         o_flush_done <= 1'b0;
         if (o_valid && i_ready) begin
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_last_bits <= '0;
         end
         if (take && illegal) begin
            o_err <= 1'b1;
         end
         if (take_code) begin
            o_total_bits <= o_total_bits + CNT_WIDTH'(len);
            if (nf >= FW'(OUT_WIDTH)) begin
               o_data      <= nbuf[BUF_W-1 -: OUT_WIDTH];
               o_valid     <= 1'b1;
               o_last      <= 1'b0;
               o_last_bits <= '0;
               sbuf        <= nbuf << OUT_WIDTH;
               fill        <= nf - FW'(OUT_WIDTH);
            end else begin
               sbuf <= nbuf;
               fill <= nf;
            end
         end
         unique case (state)
            S_RUN: begin
               if (i_flush && o_ready) begin
                  state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (out_free) begin
                  if (fill != '0) begin
                     o_data      <= sbuf[BUF_W-1 -: OUT_WIDTH];
                     o_valid     <= 1'b1;
                     o_last      <= 1'b1;
                     o_last_bits <= 7'(fill);
                  end
                  fill         <= '0;
                  sbuf         <= '0;
                  o_flush_done <= 1'b1;
                  state        <= S_RUN;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_code_bit_packer.sv
// Scoreboard bench for code_bit_packer with a bit-queue reference model.
// Directed scenarios followed by randomized codes, flushes and backpressure.
module tb_code_bit_packer;

   localparam int OW = 64;
   localparam int TB = 34;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_flush = 1'b0;
   logic [2:0]    i_code = '0;
   logic [TB-1:0] i_compressed_word = '0;
   logic          ready_force = 1'b1;
   logic          rnd_ready = 1'b0;
   logic          rnd_bit = 1'b1;
   logic          i_ready;
   logic          o_ready;
   logic          o_valid;
   logic [OW-1:0] o_data;
   logic          o_last;
   logic [6:0]    o_last_bits;
   logic          o_flush_done;
   logic [CW-1:0] o_total_bits;
   logic          o_err;

   assign i_ready = rnd_ready ? rnd_bit : ready_force;

   code_bit_packer #(
      .TOTAL_BITS (TB),
      .OUT_WIDTH  (OW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_valid           (i_valid),
      .o_ready           (o_ready),
      .i_code            (i_code),
      .i_compressed_word (i_compressed_word),
      .i_flush           (i_flush),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_data            (o_data),
      .o_last            (o_last),
      .o_last_bits       (o_last_bits),
      .o_flush_done      (o_flush_done),
      .o_total_bits      (o_total_bits),
      .o_err             (o_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   typedef struct {
      logic [OW-1:0] d;
      logic          l;
      logic [6:0]    lb;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   bit          bits[$];
   longint      m_total = 0;
   bit          m_err = 0;
   bit          pend = 0;
   bit          mon_en = 0;
   int          done_cnt = 0;

   function automatic int clen(input logic [2:0] c);
      case (c)
         3'd0: return 2;
         3'd1: return 6;
         3'd2: return 12;
         3'd3: return 16;
         3'd4: return 24;
         3'd5: return 34;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void emit(input bit last);
      exp_t e;
      int   n;
      e.d = '0;
      n = (bits.size() < OW) ? bits.size() : OW;
      for (int i = 0; i < n; i++) e.d[OW-1-i] = bits.pop_front();
      e.l  = last;
      e.lb = last ? 7'(n) : 7'd0;
      exp_q.push_back(e);
   endfunction

   function automatic void model_code(input logic [2:0] c,
                                      input logic [TB-1:0] w);
      int L;
      L = clen(c);
      for (int i = L - 1; i >= 0; i--) bits.push_back(w[i]);
      m_total += L;
      while (bits.size() >= OW) emit(1'b0);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (rst) begin
            exp_q.delete();
            bits.delete();
            m_total = 0;
            m_err   = 0;
            pend    = 0;
         end else begin
            check("total_bits", 128'(o_total_bits), 128'(m_total[CW-1:0]));
            check("err", 128'(o_err), 128'(m_err));
            if (o_flush_done) begin
               done_cnt++;
               checks++;
               if (!pend) begin
                  errors++;
                  $display("FAIL flush_done: got unexpected pulse expected none");
               end
               pend = 0;
            end
            if (o_valid && i_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL word: got %0h expected no word", o_data);
               end else begin
                  e = exp_q.pop_front();
                  check("data", 128'(o_data), 128'(e.d));
                  check("last", 128'(o_last), 128'(e.l));
                  check("last_bits", 128'(o_last_bits), 128'(e.lb));
               end
            end
            if (i_valid && o_ready) begin
               if (clen(i_code) == 0) m_err = 1;
               else model_code(i_code, i_compressed_word);
            end
            if (i_flush && o_ready) begin
               if (bits.size() > 0) emit(1'b1);
               pend = 1;
            end
         end
      end
   end

   task automatic beat(input logic [2:0] c, input logic [TB-1:0] w,
                       input logic v, input logic f);
      int n = 0;
      @(posedge clk);
      #1;
      i_valid = v;
      i_flush = f;
      i_code  = c;
      i_compressed_word = w;
      do begin
         @(negedge clk);
         n++;
      end while (!o_ready && n < 200);
      if (!o_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got o_ready=0 expected 1");
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || pend) begin
         errors++;
         $display("FAIL drain: got %0d words pending expected 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 128'(o_valid), 128'(0));
      check("rst_ready", 128'(o_ready), 128'(1));
      check("rst_err", 128'(o_err), 128'(0));
      check("rst_total", 128'(o_total_bits), 128'(0));
   endtask

   initial begin
      logic [TB-1:0] dbe;
      logic [63:0]   r;
      logic [2:0]    c;
      int            L;
      int            d0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_valid", 128'(o_valid), 128'(0));
      check("rst_ready", 128'(o_ready), 128'(1));
      check("rst_err", 128'(o_err), 128'(0));
      check("rst_total", 128'(o_total_bits), 128'(0));

      repeat (32) beat(3'b000, '0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check("total_64", 128'(o_total_bits), 128'(64));
      drain();

      dbe = {2'b01, 32'hDEADBEEF};
      beat(3'b101, dbe, 1'b1, 1'b0);
      beat(3'b101, dbe, 1'b1, 1'b0);
      beat(3'b000, '0, 1'b0, 1'b1);
      drain();

      ready_force = 1'b0;
      beat(3'b101, dbe, 1'b1, 1'b0);
      beat(3'b101, 34'h1_2345_6789, 1'b1, 1'b0);
      repeat (10) begin
         @(negedge clk);
         check("bp_ready", 128'(o_ready), 128'(0));
         check("bp_valid", 128'(o_valid), 128'(1));
         check("bp_data", 128'(o_data),
               128'(exp_q.size() ? exp_q[0].d : 64'hx));
      end
      ready_force = 1'b1;
      beat(3'b000, '0, 1'b0, 1'b1);
      drain();

      beat(3'b111, 34'h3, 1'b1, 1'b0);
      beat(3'b001, 34'h2D, 1'b1, 1'b0);
      @(negedge clk);
      check("err_sticky", 128'(o_err), 128'(1));
      beat(3'b000, '0, 1'b0, 1'b1);
      drain();
      d0 = done_cnt;
      beat(3'b000, '0, 1'b0, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      check("flush_empty_done", 128'(done_cnt - d0), 128'(1));
      check("flush_empty_valid", 128'(o_valid), 128'(0));

      beat(3'b100, 34'hABCDEF, 1'b1, 1'b0);
      beat(3'b100, 34'h123456, 1'b1, 1'b0);
      beat(3'b010, 34'hFED, 1'b1, 1'b0);
      beat(3'b011, 34'hBEEF, 1'b1, 1'b1);
      drain();

      ready_force = 1'b0;
      beat(3'b100, 34'hFFFFFF, 1'b1, 1'b0);
      beat(3'b011, 34'h5A5A, 1'b1, 1'b0);
      beat(3'b101, dbe, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      ready_force = 1'b1;
      do_reset();
      repeat (5) @(negedge clk);
      check("rst_flush_valid", 128'(o_valid), 128'(0));

      rnd_ready = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 19) == 0) c = 3'($urandom_range(6, 7));
         else c = 3'($urandom_range(0, 5));
         L = clen(c);
         r = {$urandom, $urandom};
         beat(c, r[TB-1:0] & ((34'd1 << L) - 34'd1),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
      end
      beat(3'b000, '0, 1'b0, 1'b1);
      drain();
      rnd_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
